// File: rtl/cache_mesi_array.sv
// cache_mesi_array: per-set MESI/MOESI coherence state tracker for a direct-mapped L1
//
// Tracks one coherence state per set. Processor requests are serialised into
// bus commands through a req/grant handshake. Snooped bus commands update
// the addressed set in the same clock.
//
// Optional feature macro: MESI_OWNED_EN (MOESI). When it is defined, a snooped
// BusRd moves M to O instead of S, and O then serves read hits and upgrades.
//
// Ports
//   clk               clock
//   rstb              asynchronous, active-low reset
//   i_pr_valid        processor request valid
//   i_pr_wr           1=write, 0=read
//   i_pr_idx          processor set index
//   o_pr_ready        idle; request accepted on i_pr_valid & o_pr_ready
//   o_pr_done         one-cycle completion pulse
//   o_bus_req_valid   bus command pending, held until granted
//   o_bus_req_cmd     01=BusRd 10=BusRdX 11=BusUpgr, 00 when idle
//   o_bus_req_idx     index of the pending command
//   i_bus_grant       arbiter grant
//   i_c_in            shared line from other caches, sampled on the grant edge
//   i_snp_valid       snooped command valid
//   i_snp_cmd         snooped command, same encoding as o_bus_req_cmd
//   i_snp_idx         snooped set index
//   o_snp_flush       line was dirty (M/O) when snooped
//   o_snp_shared      line was valid when snooped
module cache_mesi_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             i_pr_valid,
  input  logic             i_pr_wr,
  input  logic [IDX_W-1:0] i_pr_idx,
  output logic             o_pr_ready,
  output logic             o_pr_done,
  output logic             o_bus_req_valid,
  output logic [1:0]       o_bus_req_cmd,
  output logic [IDX_W-1:0] o_bus_req_idx,
  input  logic             i_bus_grant,
  input  logic             i_c_in,
  input  logic             i_snp_valid,
  input  logic [1:0]       i_snp_cmd,
  input  logic [IDX_W-1:0] i_snp_idx,
  output logic             o_snp_flush,
  output logic             o_snp_shared
);
  localparam logic [2:0] ST_I = 3'b000;
  localparam logic [2:0] ST_S = 3'b001;
  localparam logic [2:0] ST_E = 3'b010;
  localparam logic [2:0] ST_M = 3'b011;
  localparam logic [2:0] ST_O = 3'b100;
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_RDX  = 2'b10;
  localparam logic [1:0] CMD_UPGR = 2'b11;
`ifdef MESI_OWNED_EN
  localparam logic [2:0] M_ON_BUSRD = ST_O;
`else
  localparam logic [2:0] M_ON_BUSRD = ST_S;
`endif
  typedef enum logic {IDLE, WAIT_GNT} state_t;
  state_t           r_state;
  logic [2:0]       r_line [NUM_SETS];
  logic [1:0]       r_req_cmd;
  logic [IDX_W-1:0] r_req_idx;
  logic             r_done;
  logic             r_flush;
  logic             r_shared;
  logic [2:0]       w_line_next [NUM_SETS];
  logic             w_snp_hit;
  logic [2:0]       w_snp_old;
  logic [2:0]       w_snp_new;
  logic             w_acc;
  logic [2:0]       w_pr_cur;
  logic [1:0]       w_pr_cmd;
  logic [2:0]       w_pr_new;
  logic             w_grant;
  logic             w_upgr_lost;
  // A snoop with command 00 is a no-op, so it does not count as a hit.
  assign w_snp_hit = i_snp_valid && i_snp_cmd != CMD_NONE;
  assign w_snp_old = r_line[i_snp_idx];
  // O keeps O on BusRd; S and I are unchanged by BusRd.
  assign w_snp_new = i_snp_cmd != CMD_RD ? ST_I :
                     w_snp_old == ST_E   ? ST_S :
                     w_snp_old == ST_M   ? M_ON_BUSRD : w_snp_old;
  assign w_acc = i_pr_valid && r_state == IDLE;
  // The processor decision sees the line after a same-edge snoop.
  assign w_pr_cur = (w_snp_hit && i_snp_idx == i_pr_idx) ? w_snp_new : r_line[i_pr_idx];
  assign w_pr_cmd = !i_pr_wr ? (w_pr_cur == ST_I ? CMD_RD : CMD_NONE) :
                    w_pr_cur == ST_I ? CMD_RDX :
                    (w_pr_cur == ST_S || w_pr_cur == ST_O) ? CMD_UPGR : CMD_NONE;
  assign w_pr_new = i_pr_wr ? ST_M : w_pr_cur;
  assign w_grant = r_state == WAIT_GNT && i_bus_grant;
  // Losing the line while an upgrade waits means the data must be refetched.
  assign w_upgr_lost = r_state == WAIT_GNT && !i_bus_grant && w_snp_hit &&
                       i_snp_idx == r_req_idx && w_snp_new == ST_I && r_req_cmd == CMD_UPGR;
  always_comb begin
    w_line_next = r_line;
    if (w_snp_hit) w_line_next[i_snp_idx] = w_snp_new;
    if (w_grant) w_line_next[r_req_idx] = r_req_cmd == CMD_RD ? (i_c_in ? ST_S : ST_E) : ST_M;
    if (w_acc && w_pr_cmd == CMD_NONE) w_line_next[i_pr_idx] = w_pr_new;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= IDLE;
      r_line    <= '{default: ST_I};
      r_req_cmd <= CMD_NONE;
      r_req_idx <= '0;
      r_done    <= 1'b0;
      r_flush   <= 1'b0;
      r_shared  <= 1'b0;
    end else begin
      r_line   <= w_line_next;
      r_flush  <= w_snp_hit && (w_snp_old == ST_M || w_snp_old == ST_O);
      r_shared <= w_snp_hit && w_snp_old != ST_I;
      r_done   <= w_grant || (w_acc && w_pr_cmd == CMD_NONE);
      if (w_acc && w_pr_cmd != CMD_NONE) begin
        r_state   <= WAIT_GNT;
        r_req_cmd <= w_pr_cmd;
        r_req_idx <= i_pr_idx;
      end else if (w_grant) begin
        r_state   <= IDLE;
        r_req_cmd <= CMD_NONE;
        r_req_idx <= '0;
      end else if (w_upgr_lost) begin
        r_req_cmd <= CMD_RDX;
      end
    end
  end
  assign o_pr_ready      = r_state == IDLE;
  assign o_pr_done       = r_done;
  assign o_bus_req_valid = r_state == WAIT_GNT;
  assign o_bus_req_cmd   = r_req_cmd;
  assign o_bus_req_idx   = r_req_idx;
  assign o_snp_flush     = r_flush;
  assign o_snp_shared    = r_shared;
endmodule

// File: tb/tb_cache_mesi_array.sv
// tb_cache_mesi_array: directed self-checking bench for cache_mesi_array
module tb_cache_mesi_array;
  localparam int IDX_W = 4;
  logic clk = 1'b0, rstb = 1'b0;
  logic pr_valid = 0, pr_wr = 0, bus_grant = 0, c_in = 0, snp_valid = 0;
  logic [IDX_W-1:0] pr_idx = '0, snp_idx = '0;
  logic [1:0] snp_cmd = 2'b00;
  logic pr_ready, pr_done, bus_req_valid, snp_flush, snp_shared;
  logic [1:0] bus_req_cmd;
  logic [IDX_W-1:0] bus_req_idx;
  int n_tests = 0, n_fail = 0;
`ifdef MESI_OWNED_EN
  localparam logic [2:0] EXP_M_BUSRD = 3'b100;
  localparam logic EXP_SAME_FLUSH = 1'b1;
`else
  localparam logic [2:0] EXP_M_BUSRD = 3'b001;
  localparam logic EXP_SAME_FLUSH = 1'b0;
`endif
  cache_mesi_array #(.NUM_SETS(16)) dut (
    .clk(clk), .rstb(rstb),
    .i_pr_valid(pr_valid), .i_pr_wr(pr_wr), .i_pr_idx(pr_idx),
    .o_pr_ready(pr_ready), .o_pr_done(pr_done),
    .o_bus_req_valid(bus_req_valid), .o_bus_req_cmd(bus_req_cmd), .o_bus_req_idx(bus_req_idx),
    .i_bus_grant(bus_grant), .i_c_in(c_in),
    .i_snp_valid(snp_valid), .i_snp_cmd(snp_cmd), .i_snp_idx(snp_idx),
    .o_snp_flush(snp_flush), .o_snp_shared(snp_shared)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    tick();
    tick();
    n_tests++; if (pr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", pr_ready); end
    n_tests++; if (pr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", pr_done); end
    n_tests++; if (bus_req_valid !== 1'b0 || bus_req_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_bus: got v=%b cmd=%b exp 0/00", bus_req_valid, bus_req_cmd); end
    n_tests++; if (snp_flush !== 1'b0 || snp_shared !== 1'b0) begin n_fail++; $display("FAIL reset_snp: got f=%b s=%b exp 0/0", snp_flush, snp_shared); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (dut.r_line[i] !== 3'b000) begin n_fail++; $display("FAIL reset_line%0d: got %b exp 000", i, dut.r_line[i]); end
    end
    rstb = 1'b1;
    tick();
  endtask
  task automatic test_read_miss();
    pr_valid = 1; pr_wr = 0; pr_idx = 3;
    tick();
    pr_valid = 0;
    n_tests++; if (pr_ready !== 1'b0 || bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL rdmiss_req: got rdy=%b v=%b exp 0/1", pr_ready, bus_req_valid); end
    n_tests++; if (bus_req_cmd !== 2'b01 || bus_req_idx !== 4'd3) begin n_fail++; $display("FAIL rdmiss_cmd: got cmd=%b idx=%0d exp 01/3", bus_req_cmd, bus_req_idx); end
    n_tests++; if (pr_done !== 1'b0) begin n_fail++; $display("FAIL rdmiss_early_done: got %b exp 0", pr_done); end
    tick();
    n_tests++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL rdmiss_hold: got %b exp 1", bus_req_valid); end
    bus_grant = 1; c_in = 0;
    tick();
    bus_grant = 0;
    n_tests++; if (pr_done !== 1'b1 || bus_req_valid !== 1'b0 || pr_ready !== 1'b1) begin n_fail++; $display("FAIL rdmiss_grant: got done=%b v=%b rdy=%b exp 1/0/1", pr_done, bus_req_valid, pr_ready); end
    n_tests++; if (dut.r_line[3] !== 3'b010) begin n_fail++; $display("FAIL rdmiss_line: got %b exp 010", dut.r_line[3]); end
    n_tests++; if (bus_req_cmd !== 2'b00) begin n_fail++; $display("FAIL rdmiss_cmd_idle: got %b exp 00", bus_req_cmd); end
    tick();
    n_tests++; if (pr_done !== 1'b0) begin n_fail++; $display("FAIL rdmiss_done_pulse: got %b exp 0", pr_done); end
  endtask
  task automatic test_write_e();
    pr_valid = 1; pr_wr = 1; pr_idx = 3;
    tick();
    pr_valid = 0;
    n_tests++; if (pr_done !== 1'b1 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL wr_e: got done=%b v=%b exp 1/0", pr_done, bus_req_valid); end
    n_tests++; if (dut.r_line[3] !== 3'b011) begin n_fail++; $display("FAIL wr_e_line: got %b exp 011", dut.r_line[3]); end
    tick();
  endtask
  task automatic test_snoop_noop();
    snp_valid = 1; snp_cmd = 2'b00; snp_idx = 3;
    tick();
    snp_valid = 0;
    n_tests++; if (snp_flush !== 1'b0 || snp_shared !== 1'b0 || dut.r_line[3] !== 3'b011) begin n_fail++; $display("FAIL snp_noop: got f=%b s=%b line=%b exp 0/0/011", snp_flush, snp_shared, dut.r_line[3]); end
  endtask
  task automatic test_read_hit();
    pr_valid = 1; pr_wr = 0; pr_idx = 3;
    tick();
    pr_valid = 0;
    n_tests++; if (pr_done !== 1'b1 || bus_req_valid !== 1'b0 || dut.r_line[3] !== 3'b011) begin n_fail++; $display("FAIL rd_hit: got done=%b v=%b line=%b exp 1/0/011", pr_done, bus_req_valid, dut.r_line[3]); end
    tick();
  endtask
  task automatic test_snoop_m();
    snp_valid = 1; snp_cmd = 2'b01; snp_idx = 3;
    tick();
    snp_valid = 0;
    n_tests++; if (snp_flush !== 1'b1 || snp_shared !== 1'b1) begin n_fail++; $display("FAIL snp_m_out: got f=%b s=%b exp 1/1", snp_flush, snp_shared); end
    n_tests++; if (dut.r_line[3] !== EXP_M_BUSRD) begin n_fail++; $display("FAIL snp_m_line: got %b exp %b", dut.r_line[3], EXP_M_BUSRD); end
    tick();
    n_tests++; if (snp_flush !== 1'b0 || snp_shared !== 1'b0) begin n_fail++; $display("FAIL snp_m_pulse: got f=%b s=%b exp 0/0", snp_flush, snp_shared); end
  endtask
  task automatic test_upgr_convert();
    pr_valid = 1; pr_wr = 0; pr_idx = 5;
    tick();
    pr_valid = 0; bus_grant = 1; c_in = 1;
    tick();
    bus_grant = 0; c_in = 0;
    n_tests++; if (dut.r_line[5] !== 3'b001) begin n_fail++; $display("FAIL upg_shared_fill: got %b exp 001", dut.r_line[5]); end
    tick();
    pr_valid = 1; pr_wr = 1; pr_idx = 5;
    tick();
    pr_valid = 0;
    n_tests++; if (bus_req_cmd !== 2'b11 || bus_req_idx !== 4'd5) begin n_fail++; $display("FAIL upg_cmd: got cmd=%b idx=%0d exp 11/5", bus_req_cmd, bus_req_idx); end
    snp_valid = 1; snp_cmd = 2'b11; snp_idx = 5;
    tick();
    snp_valid = 0;
    n_tests++; if (bus_req_cmd !== 2'b10 || bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL upg_convert: got cmd=%b v=%b exp 10/1", bus_req_cmd, bus_req_valid); end
    n_tests++; if (dut.r_line[5] !== 3'b000 || snp_shared !== 1'b1 || snp_flush !== 1'b0) begin n_fail++; $display("FAIL upg_snoop: got line=%b s=%b f=%b exp 000/1/0", dut.r_line[5], snp_shared, snp_flush); end
    bus_grant = 1;
    tick();
    bus_grant = 0;
    n_tests++; if (dut.r_line[5] !== 3'b011 || pr_done !== 1'b1 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL upg_final: got line=%b done=%b v=%b exp 011/1/0", dut.r_line[5], pr_done, bus_req_valid); end
    tick();
  endtask
  task automatic test_snoop_invalid();
    snp_valid = 1; snp_cmd = 2'b10; snp_idx = 7;
    tick();
    snp_valid = 0;
    n_tests++; if (snp_flush !== 1'b0 || snp_shared !== 1'b0 || dut.r_line[7] !== 3'b000) begin n_fail++; $display("FAIL snp_inv: got f=%b s=%b line=%b exp 0/0/000", snp_flush, snp_shared, dut.r_line[7]); end
  endtask
  task automatic test_same_edge();
    pr_valid = 1; pr_wr = 1; pr_idx = 3;
    snp_valid = 1; snp_cmd = 2'b10; snp_idx = 3;
    tick();
    pr_valid = 0; snp_valid = 0;
    n_tests++; if (bus_req_cmd !== 2'b10 || bus_req_valid !== 1'b1) begin n_fail++; $display("FAIL same_cmd: got cmd=%b v=%b exp 10/1", bus_req_cmd, bus_req_valid); end
    n_tests++; if (dut.r_line[3] !== 3'b000 || snp_flush !== EXP_SAME_FLUSH || snp_shared !== 1'b1) begin n_fail++; $display("FAIL same_snoop: got line=%b f=%b s=%b exp 000/%b/1", dut.r_line[3], snp_flush, snp_shared, EXP_SAME_FLUSH); end
    bus_grant = 1; c_in = 1;
    tick();
    bus_grant = 0; c_in = 0;
    n_tests++; if (dut.r_line[3] !== 3'b011 || pr_done !== 1'b1) begin n_fail++; $display("FAIL same_final: got line=%b done=%b exp 011/1", dut.r_line[3], pr_done); end
    tick();
  endtask
  task automatic test_reset_mid();
    pr_valid = 1; pr_wr = 0; pr_idx = 9;
    tick();
    pr_wr = 1; pr_idx = 2;
    tick();
    pr_valid = 0;
    n_tests++; if (bus_req_cmd !== 2'b01 || bus_req_idx !== 4'd9 || dut.r_line[2] !== 3'b000) begin n_fail++; $display("FAIL busy_ignore: got cmd=%b idx=%0d line2=%b exp 01/9/000", bus_req_cmd, bus_req_idx, dut.r_line[2]); end
    rstb = 0;
    #1;
    n_tests++; if (bus_req_valid !== 1'b0 || pr_ready !== 1'b1 || bus_req_cmd !== 2'b00) begin n_fail++; $display("FAIL rst_mid_async: got v=%b rdy=%b cmd=%b exp 0/1/00", bus_req_valid, pr_ready, bus_req_cmd); end
    n_tests++; if (dut.r_line[3] !== 3'b000 || dut.r_line[5] !== 3'b000) begin n_fail++; $display("FAIL rst_mid_lines: got l3=%b l5=%b exp 000/000", dut.r_line[3], dut.r_line[5]); end
    tick();
    n_tests++; if (pr_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b exp 0", pr_done); end
    rstb = 1;
    bus_grant = 1;
    tick();
    bus_grant = 0;
    n_tests++; if (pr_done !== 1'b0 || pr_ready !== 1'b1 || dut.r_line[9] !== 3'b000) begin n_fail++; $display("FAIL rst_mid_after: got done=%b rdy=%b l9=%b exp 0/1/000", pr_done, pr_ready, dut.r_line[9]); end
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_write_e();
    test_snoop_noop();
    test_read_hit();
    test_snoop_m();
    test_upgr_convert();
    test_snoop_invalid();
    test_same_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
